fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h00400000, fetch address after reset.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rom_addr  output  32  fetch address to inst_rom (addr_in), driven directly from fetch_pc register.
REQ-005 SHALL have port rom_data  input  32  inst_rom data_out; valid one cycle after the address is sampled.
REQ-006 SHALL have port stall_in  input  1  decode not accepting; IF/ID must hold.
REQ-007 SHALL have port redirect_valid  input  1  single-cycle branch/jump redirect from EX.
REQ-008 SHALL have port redirect_target  input  32  redirect destination.
REQ-009 SHALL have port halt_in  input  1  decode has seen a halt instruction.
REQ-010 SHALL have ports if_valid (1), if_pc (32), if_instr (32)  output  registered IF/ID slot.
REQ-011 SHALL have ports halted (1), misalign_err (1)  output  status flags.
REQ-012 SHALL have ports fetch_count (32), stall_count (32)  output  performance counters.

Function
REQ-013 SHALL keep state: fetch_pc, in-flight {valid, pc}, skid {valid, pc, instr}, IF/ID slot, FSM {RUN, HALT}.
REQ-014 SHALL define advance = !stall_in || (!skid_valid && !inflight_valid); in RUN with no redirect, fetch_pc += 4 on advance, else holds.
REQ-015 SHALL load in-flight each edge: pc <= fetch_pc, valid <= advance (RUN, no redirect).
REQ-016 SHALL, when stall_in && !skid_valid && inflight_valid, capture {inflight_pc, rom_data} into skid.
REQ-017 SHALL, when !stall_in, load IF/ID from skid if skid_valid (skid then empties), else {inflight_valid, inflight_pc, rom_data}; hold IF/ID while stall_in.
REQ-018 SHALL give latency: address presented cycle n appears on if_* in cycle n+2 absent stall/redirect; no instruction skipped or duplicated across any stall length.
REQ-019 SHALL on redirect_valid (RUN): fetch_pc <= {target[31:2],2'b00}; clear in-flight, skid and IF/ID valid; overrides stall_in and halt_in; target on if_* 3 cycles after the redirect cycle.
REQ-020 SHALL set misalign_err sticky when redirect_target[1:0] != 0 at an accepted redirect.
REQ-021 SHALL on halt_in in RUN without redirect: go to HALT, clear all valids; HALT holds fetch_pc, ignores redirect/stall, exits only on reset; halted = (state==HALT).
REQ-022 SHALL increment fetch_count on each edge loading IF/ID with valid=1; stall_count on each RUN cycle with stall_in=1; both wrap modulo 2^32.
REQ-023 SHALL apply priority reset > redirect > halt > stall > normal.

Reset
REQ-024 SHALL on reset: fetch_pc=PC_RESET, state=RUN, all valids 0, if_pc=0, if_instr=0, flags 0, counters 0, regardless of stall/skid contents mid-operation.
REQ-025 SHALL present rom_addr=PC_RESET in the first cycle after reset deasserts; first if_valid two cycles later.

Structure
REQ-026 SHALL place PC_RESET default, the RUN/HALT state encoding and the 32-bit word width in a shared package processor_pkg.
REQ-027 SHALL implement the skid register as sub-module fetch_skid (capture/drain/clear); the remainder stays in fetch_controller.

Verification
REQ-028 Reset release, no stall -> if_pc 0x00400000 in cycle 2, 0x00400004 cycle 3; fetch_count=3 in cycle 4.
REQ-029 stall_in high 3 cycles while if_pc=0x00400008 -> if_* holds, next 0x0040000C, then 0x00400010; stall_count=3.
REQ-030 redirect to 0x00400100 in cycle 5 -> if_valid 0 cycles 6-7, if_pc=0x00400100 cycle 8; same with stall_in high in cycle 5.
REQ-031 redirect to 0x00400102 -> fetch 0x00400100, misalign_err=1 until reset; redirect plus halt_in in one cycle -> stays RUN.
REQ-032 halt_in -> halted=1 next cycle, if_valid 0, rom_addr frozen; redirect ignored thereafter.
REQ-033 reset asserted mid-stall with skid full -> all valids 0, counters 0, rom_addr=0x00400000 after release.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared front-end definitions: word width, reset PC, fetch FSM encoding.
// Also holds the IF/ID bundle type and small PC helpers.
package processor_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0040_0000;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic  valid;
        word_t pc;
        word_t instr;
    } if_id_t;

    function automatic word_t pc_align(input word_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic word_t pc_next(input word_t pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding the ROM word that arrives while decode stalls.
// Clear beats capture, capture beats drain.
module fetch_skid
    import processor_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            capture,
    input  logic            drain,
    input  logic            clear,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    if_id_t skid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            skid_q <= '0;
        end else if (clear) begin
            skid_q.valid <= 1'b0;
        end else if (capture) begin
            skid_q.valid <= 1'b1;
            skid_q.pc    <= pc_in;
            skid_q.instr <= instr_in;
        end else if (drain) begin
            skid_q.valid <= 1'b0;
        end
    end

    assign valid = skid_q.valid;
    assign pc    = skid_q.pc;
    assign instr = skid_q.instr;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch: PC sequencing, one-cycle ROM latency, skid-backed IF/ID.
// Redirect flushes everything; halt freezes the front end until reset.
module fetch_controller
    import processor_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] rom_addr,
    input  logic [XLEN-1:0] rom_data,
    input  logic            stall_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_in,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            halted,
    output logic            misalign_err,
    output logic [XLEN-1:0] fetch_count,
    output logic [XLEN-1:0] stall_count
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;

    logic            inflight_valid_q;
    logic [XLEN-1:0] inflight_pc_q;

    if_id_t          ifid_q;
    if_id_t          ifid_next;

    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;

    logic            misalign_q;
    logic [XLEN-1:0] fetch_count_q;
    logic [XLEN-1:0] stall_count_q;

    logic in_run;
    logic take_redirect;
    logic take_halt;
    logic run_normal;
    logic advance;
    logic skid_capture;
    logic skid_drain;
    logic skid_clear;
    logic ifid_load;

    // Priority: redirect, then halt, then stall/normal flow.
    always_comb begin
        in_run        = (state_q == RUN);
        take_redirect = in_run && redirect_valid;
        take_halt     = in_run && !redirect_valid && halt_in;
        run_normal    = in_run && !redirect_valid && !halt_in;
        advance       = !stall_in || (!skid_valid && !inflight_valid_q);
        skid_capture  = run_normal && stall_in
                        && !skid_valid && inflight_valid_q;
        skid_drain    = run_normal && !stall_in && skid_valid;
        skid_clear    = take_redirect || take_halt;
        ifid_load     = run_normal && !stall_in;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        unique case (1'b1)
            take_redirect: fetch_pc_d = pc_align(redirect_target);
            take_halt:     state_d    = HALT;
            run_normal:    begin
                if (advance) begin
                    fetch_pc_d = pc_next(fetch_pc_q);
                end
            end
            default:       ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= PC_RESET;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // A held word in the skid is always older than anything in flight.
    always_comb begin
        ifid_next = '0;
        if (skid_valid) begin
            ifid_next.valid = 1'b1;
            ifid_next.pc    = skid_pc;
            ifid_next.instr = skid_instr;
        end else begin
            ifid_next.valid = inflight_valid_q;
            ifid_next.pc    = inflight_pc_q;
            ifid_next.instr = rom_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            ifid_q           <= '0;
        end else begin
            inflight_pc_q    <= fetch_pc_q;
            inflight_valid_q <= run_normal && advance;
            if (skid_clear) begin
                ifid_q.valid <= 1'b0;
            end else if (ifid_load) begin
                ifid_q <= ifid_next;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (take_redirect && (redirect_target[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
            if (ifid_load && ifid_next.valid) begin
                fetch_count_q <= fetch_count_q + XLEN'(1);
            end
            if (in_run && stall_in) begin
                stall_count_q <= stall_count_q + XLEN'(1);
            end
        end
    end

    fetch_skid u_skid (
        .clock    (clock),
        .reset    (reset),
        .capture  (skid_capture),
        .drain    (skid_drain),
        .clear    (skid_clear),
        .pc_in    (inflight_pc_q),
        .instr_in (rom_data),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

    assign rom_addr     = fetch_pc_q;
    assign if_valid     = ifid_q.valid;
    assign if_pc        = ifid_q.pc;
    assign if_instr     = ifid_q.instr;
    assign halted       = (state_q == HALT);
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;
    assign stall_count  = stall_count_q;

endmodule
